// File: rtl/rs_tag_alloc_pkg.sv
// Shared sizing for reservation-station tag allocators: per-RS-type slot counts,
// tag widths and the "no free slot" sentinel.
package rs_tag_alloc_pkg;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_LS  = 2'd1,
    RS_BR  = 2'd2
  } rs_kind_e;

  localparam int unsigned ALU_RS_SIZE = 6;
  localparam int unsigned ALU_TAG_W   = 3;
  localparam int unsigned LS_RS_SIZE  = 8;
  localparam int unsigned LS_TAG_W    = 4;
  localparam int unsigned BR_RS_SIZE  = 4;
  localparam int unsigned BR_TAG_W    = 3;

  localparam logic [ALU_TAG_W-1:0] ALU_NO_FREE_TAG = '1;

  function automatic int unsigned rs_size(input rs_kind_e kind);
    case (kind)
      RS_LS:   return LS_RS_SIZE;
      RS_BR:   return BR_RS_SIZE;
      default: return ALU_RS_SIZE;
    endcase
  endfunction

  function automatic int unsigned rs_tag_w(input rs_kind_e kind);
    case (kind)
      RS_LS:   return LS_TAG_W;
      RS_BR:   return BR_TAG_W;
      default: return ALU_TAG_W;
    endcase
  endfunction

endpackage

// File: rtl/rs_tag_alloc_prio_enc.sv
// Lowest-set-bit priority encoder with valid; shared with RS issue-select.
module prio_enc_lsb #(
  parameter int unsigned N     = 6,
  parameter int unsigned OUT_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [OUT_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = OUT_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_tag_alloc.sv
// Reservation-station slot allocator: owns the occupancy bitmap, hands out the
// lowest free tag, reclaims tags from several release ports, supports flush.
module rs_tag_alloc
  import rs_tag_alloc_pkg::*;
#(
  parameter int unsigned      RS_SIZE     = ALU_RS_SIZE,
  parameter int unsigned      TAG_W       = ALU_TAG_W,
  parameter int unsigned      NUM_REL     = 2,
  parameter int unsigned      AFULL_THR   = 5,
  parameter logic [TAG_W-1:0] NO_FREE_TAG = ALU_NO_FREE_TAG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  output logic [TAG_W-1:0]             alloc_tag,
  output logic                         alloc_ok,
  output logic                         has_free,
  input  logic [NUM_REL-1:0]           rel_en,
  input  logic [NUM_REL*TAG_W-1:0]     rel_tag,
  input  logic                         flush,
  output logic [RS_SIZE-1:0]           busy_vec,
  output logic [$clog2(RS_SIZE+1)-1:0] count,
  output logic                         afull,
  output logic                         err_double_free
);

  localparam int unsigned        CNT_W = $clog2(RS_SIZE + 1);
  localparam logic [RS_SIZE-1:0] ONE   = {{(RS_SIZE-1){1'b0}}, 1'b1};

  if (32'(NO_FREE_TAG) < RS_SIZE) begin : g_bad_sentinel
    $error("rs_tag_alloc: NO_FREE_TAG must not alias a real slot");
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [RS_SIZE-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RS_SIZE; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic [RS_SIZE-1:0] free_vec;
  logic [TAG_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [RS_SIZE-1:0] alloc_mask;
  logic [RS_SIZE-1:0] rel_mask;
  logic [RS_SIZE-1:0] clr_mask;
  logic               rel_bad;
  logic [RS_SIZE-1:0] busy_next;
  logic [CNT_W-1:0]   count_next;
  logic               err_next;

  assign free_vec = ~busy_vec;

  prio_enc_lsb #(
    .N     (RS_SIZE),
    .OUT_W (TAG_W)
  ) u_enc (
    .req   (free_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign has_free  = enc_valid;
  assign alloc_tag = enc_valid ? enc_idx : NO_FREE_TAG;
  assign alloc_ok  = alloc_en & enc_valid & ~flush;
  assign afull     = (32'(count) >= AFULL_THR);

  always_comb begin
    rel_mask = '0;
    clr_mask = '0;
    rel_bad  = 1'b0;
    // Releases are judged against the registered bitmap only, so a tag being
    // allocated this cycle is still free and its release counts as a double free.
    // Out-of-range tags shift the mask to zero and are flagged the same way.
    for (int i = 0; i < NUM_REL; i++) begin
      rel_mask = ONE << rel_tag[i*TAG_W +: TAG_W];
      if (rel_en[i]) begin
        if ((rel_mask & busy_vec) == '0) rel_bad = 1'b1;
        clr_mask = clr_mask | (rel_mask & busy_vec);
      end
    end
    alloc_mask = alloc_ok ? (ONE << enc_idx) : '0;
    busy_next  = flush ? '0 : ((busy_vec & ~clr_mask) | alloc_mask);
    count_next = popcount(busy_next);
    err_next   = err_double_free | (rel_bad & ~flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec        <= '0;
      count           <= '0;
      err_double_free <= 1'b0;
    end else begin
      busy_vec        <= busy_next;
      count           <= count_next;
      err_double_free <= err_next;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (32'(count) <= RS_SIZE);
      assert (!has_free || (32'(alloc_tag) < RS_SIZE));
    end
  end

endmodule

// File: tb/tb_rs_tag_alloc.sv
// Directed plus randomized bench for rs_tag_alloc against a slot-array model.
module tb_rs_tag_alloc;

  localparam int RS    = 6;
  localparam int TW    = 3;
  localparam int NR    = 2;
  localparam int THR   = 5;
  localparam int NOFREE = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_en;
  logic [TW-1:0] alloc_tag;
  logic          alloc_ok;
  logic          has_free;
  logic [NR-1:0] rel_en;
  logic [NR*TW-1:0] rel_tag;
  logic          flush;
  logic [RS-1:0] busy_vec;
  logic [2:0]    count;
  logic          afull;
  logic          err_double_free;

  int tests = 0;
  int fails = 0;

  bit occ [RS];
  bit m_err;

  rs_tag_alloc #(
    .RS_SIZE     (RS),
    .TAG_W       (TW),
    .NUM_REL     (NR),
    .AFULL_THR   (THR),
    .NO_FREE_TAG (3'b111)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_en        (alloc_en),
    .alloc_tag       (alloc_tag),
    .alloc_ok        (alloc_ok),
    .has_free        (has_free),
    .rel_en          (rel_en),
    .rel_tag         (rel_tag),
    .flush           (flush),
    .busy_vec        (busy_vec),
    .count           (count),
    .afull           (afull),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RS; i++) n += occ[i];
    return n;
  endfunction

  function automatic int m_free_tag();
    for (int i = 0; i < RS; i++) if (!occ[i]) return i;
    return NOFREE;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < RS; i++) v[i] = occ[i];
    return v;
  endfunction

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit ae, input bit [1:0] re, input int t0, input int t1,
                      input bit fl, input bit rs);
    int  ft;
    bit  ok;
    bit  clr [RS];
    int  tg [2];
    alloc_en = ae;
    rel_en   = re;
    rel_tag  = {3'(t1), 3'(t0)};
    flush    = fl;
    rst      = rs;
    #1;
    ft = m_free_tag();
    ok = ae && (ft != NOFREE) && !fl;
    chk("alloc_tag", 32'(alloc_tag), ft);
    chk("has_free", 32'(has_free), 32'(ft != NOFREE));
    chk("alloc_ok", 32'(alloc_ok), 32'(ok));
    chk("busy_vec", 32'(busy_vec), m_vec());
    chk("count", 32'(count), m_count());
    chk("afull", 32'(afull), 32'(m_count() >= THR));
    chk("err_double_free", 32'(err_double_free), 32'(m_err));
    tg[0] = t0;
    tg[1] = t1;
    if (rs) begin
      for (int i = 0; i < RS; i++) occ[i] = 0;
      m_err = 0;
    end else if (fl) begin
      for (int i = 0; i < RS; i++) occ[i] = 0;
    end else begin
      for (int i = 0; i < RS; i++) clr[i] = 0;
      for (int p = 0; p < NR; p++) begin
        if (re[p]) begin
          if (tg[p] >= RS || !occ[tg[p]]) m_err = 1;
          else clr[tg[p]] = 1;
        end
      end
      for (int i = 0; i < RS; i++) if (clr[i]) occ[i] = 0;
      if (ok) occ[ft] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc_n(input int n);
    for (int k = 0; k < n; k++) step(1, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    alloc_en = 0; rel_en = 0; rel_tag = 0; flush = 0; rst = 1;
    for (int i = 0; i < RS; i++) occ[i] = 0;
    m_err = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Fill from empty: tags 0..5, then the sentinel.
    alloc_n(7);
    // Release 3 and 1 together, then reallocate them in order.
    step(0, 2'b11, 3, 1, 0, 0);
    alloc_n(2);
    // Build 000111, then alloc while releasing tag 0.
    step(0, 2'b00, 0, 0, 1, 0);
    alloc_n(3);
    step(1, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    // Duplicate release of one busy tag: cleared once, no error.
    step(0, 2'b11, 2, 2, 0, 0);
    // Build 000001, release non-busy tag 4, error stays sticky.
    step(0, 2'b00, 0, 0, 1, 0);
    alloc_n(1);
    step(0, 2'b01, 4, 0, 0, 0);
    alloc_n(3);
    step(0, 2'b10, 0, 1, 0, 0);
    // Build 011011, then flush with alloc and a release in the same cycle.
    step(0, 2'b00, 0, 0, 1, 0);
    alloc_n(5);
    step(0, 2'b01, 2, 0, 0, 0);
    step(1, 2'b01, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    // Reset mid-stream while full and allocating.
    alloc_n(6);
    step(1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0);
    // Out-of-range release and release of the tag being allocated.
    step(0, 2'b10, 0, 6, 0, 0);
    step(0, 2'b00, 0, 0, 0, 1);
    step(1, 2'b01, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
